// File: rtl/ctrl_pipe_chain_if.sv
// Bundle of the control-pipeline signals between decode/hazard logic and
// the pipe. The master side (decode + hazard unit) drives the control word,
// stall/flush requests and counter clear; the slave side (the pipe) returns
// per-stage words, valid bits, stall counters and in_ready.
interface ctrl_pipe_chain_if #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
);
  logic [WIDTH-1:0]        ctrl_in;
  logic                    valid_in;
  logic                    in_ready;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic [STAGES*WIDTH-1:0] ctrl_out;
  logic [STAGES-1:0]       valid_out;
  logic [STAGES*CNT_W-1:0] stall_cnt;
  logic                    cnt_clr;

  modport master (
    output ctrl_in, valid_in, stall, flush, cnt_clr,
    input  in_ready, ctrl_out, valid_out, stall_cnt
  );

  modport slave (
    input  ctrl_in, valid_in, stall, flush, cnt_clr,
    output in_ready, ctrl_out, valid_out, stall_cnt
  );
endinterface

// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline from decode through STAGES downstream stages.
// Handshake: a word on ctrl_in with valid_in=1 is taken into stage 0 on a
// clock edge exactly when in_ready=1 at that edge; in_ready depends only on
// stall, so decode must hold its word steady while in_ready=0. valid_in=0
// means "no instruction" and loads a bubble (ctrl forced to zero).
// Each stage obeys flush > hold > advance. A stall on stage i freezes stage i
// and every earlier stage; the stage just after a frozen stage takes a bubble.
// A stage whose valid bit is 0 always carries an all-zero control word, so
// write enables can never leak out of a bubble.
module ctrl_pipe_chain #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  ctrl_pipe_chain_if.slave bus
);

  logic [STAGES-1:0] holdVec;
  logic [STAGES-1:0] srcValid;
  logic [WIDTH-1:0]  srcCtrl    [STAGES];
  logic [STAGES-1:0] stageValid;
  logic [WIDTH-1:0]  stageCtrl  [STAGES];
  logic [CNT_W-1:0]  stallCount [STAGES];

  // Hold vector: a stall on stage i or any later stage freezes stage i.
  always_comb begin
    holdVec = '0;
    for (int i = 0; i < STAGES; i++) begin
      holdVec[i] = |(bus.stall >> i);
    end
  end

  assign bus.in_ready = ~holdVec[0];

  // Advance source per stage: decode for stage 0, else previous stage or a
  // bubble when the previous stage is frozen.
  always_comb begin
    srcValid   = '0;
    srcValid[0] = bus.valid_in;
    for (int i = 0; i < STAGES; i++) begin
      srcCtrl[i] = '0;
    end
    srcCtrl[0] = bus.valid_in ? bus.ctrl_in : '0;
    for (int i = 1; i < STAGES; i++) begin
      srcValid[i] = ~holdVec[i-1] & stageValid[i-1];
      srcCtrl[i]  = holdVec[i-1] ? '0 : stageCtrl[i-1];
    end
  end

  // Stage registers: flush kills, hold freezes, otherwise take the source.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stageValid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stageCtrl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (bus.flush[i]) begin
          stageValid[i] <= 1'b0;
          stageCtrl[i]  <= '0;
        end else if (holdVec[i]) begin
          stageValid[i] <= stageValid[i];
          stageCtrl[i]  <= stageCtrl[i];
        end else begin
          stageValid[i] <= srcValid[i];
          stageCtrl[i]  <= srcCtrl[i];
        end
      end
    end
  end

  // Stall counters: count edges where a real instruction waits under hold;
  // saturate at all-ones, clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stallCount[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (bus.cnt_clr) begin
          stallCount[i] <= '0;
        end else if (holdVec[i] && stageValid[i] &&
                     (stallCount[i] != {CNT_W{1'b1}})) begin
          stallCount[i] <= stallCount[i] + 1'b1;
        end
      end
    end
  end

  // Flatten per-stage state onto the output buses.
  always_comb begin
    bus.ctrl_out  = '0;
    bus.stall_cnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      bus.ctrl_out[i*WIDTH +: WIDTH]  = stageCtrl[i];
      bus.stall_cnt[i*CNT_W +: CNT_W] = stallCount[i];
    end
  end

  assign bus.valid_out = stageValid;

endmodule
